// File: rtl/pump_lock_monitor_if.sv
// Purpose : bundles the monitor's run/pump inputs and its windowed result bus.
// Latency : n/a (wiring only); results are registered inside the monitor.
// Backpressure: none; result_valid is a single-cycle pulse with no ready.
// Ports   : enable, pump (in to monitor); duty, phase_error, edge_count,
//           result_valid, locked, pump_stuck (out of monitor).
interface pump_lock_monitor_if #(
   parameter int WINDOW_LOG2 = 16
);
   logic                          enable;
   logic                          pump;
   logic [WINDOW_LOG2:0]          duty;
   logic signed [WINDOW_LOG2+1:0] phase_error;
   logic [WINDOW_LOG2:0]          edge_count;
   logic                          result_valid;
   logic                          locked;
   logic                          pump_stuck;

   // master: the monitor itself; slave: whoever drives it and reads results
   modport master (
      input  enable, pump,
      output duty, phase_error, edge_count, result_valid, locked, pump_stuck
   );

   modport slave (
      output enable, pump,
      input  duty, phase_error, edge_count, result_valid, locked, pump_stuck
   );
endinterface

// File: rtl/pump_lock_monitor.sv
// Purpose : measures XOR phase-detector pump duty/edges per 2^WINDOW_LOG2-cycle
//           window, reports signed phase error and a hysteretic lock flag.
// Latency : pump->sample 2 cycles; results one cycle after the window's last cycle.
// Backpressure: none; result_valid pulses one cycle, outputs hold until next window.
// Ports   : clk_in, reset_n (async active-low); mon = master side of
//           pump_lock_monitor_if (enable, pump in; duty, phase_error,
//           edge_count, result_valid, locked, pump_stuck out).
module pump_lock_monitor #(
   parameter int WINDOW_LOG2  = 16,
   parameter int TOL          = 1024,
   parameter int MIN_EDGES    = 4,
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 2
) (
   input  logic                  clk_in,
   input  logic                  reset_n,
   pump_lock_monitor_if.master   mon
);

   localparam int WL     = WINDOW_LOG2;
   localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
   localparam int CNT_W  = $clog2(CNT_MAX + 1);

   localparam logic [WL+1:0]        HALF_V   = (WL+2)'(2 ** (WL - 1));
   localparam logic signed [WL+1:0] TOL_P    = (WL+2)'(TOL);
   localparam logic signed [WL+1:0] NTOL_P   = -TOL_P;
   localparam logic [WL:0]          MIN_E    = (WL+1)'(MIN_EDGES);
   localparam logic [CNT_W-1:0]     LOCK_C   = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0]     UNLOCK_C = CNT_W'(UNLOCK_COUNT);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   // ---------------- synchroniser (free-running, reset only) ----------------
   logic pump_meta;
   logic pump_sync;
   logic pump_sync_d;
   logic edge_flag;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         pump_meta   <= 1'b0;
         pump_sync   <= 1'b0;
         pump_sync_d <= 1'b0;
      end else begin
         pump_meta   <= mon.pump;
         pump_sync   <= pump_meta;
         pump_sync_d <= pump_sync;
      end
   end

   assign edge_flag = pump_sync ^ pump_sync_d;

   // ---------------- window accumulation ----------------
   logic [WL-1:0]          win_cnt;
   logic [WL:0]            high_acc;
   logic [WL:0]            edge_acc;
   logic [WL:0]            high_sum;
   logic [WL:0]            edge_sum;
   logic [WL+1:0]          pe_nxt;
   logic                   win_end;

   logic [WL:0]            duty_q;
   logic signed [WL+1:0]   phase_error_q;
   logic [WL:0]            edge_count_q;
   logic                   pump_stuck_q;
   logic                   result_valid_q;

   // Totals include the closing cycle's sample, so report from the sums.
   assign high_sum = high_acc + {{WL{1'b0}}, pump_sync};
   assign edge_sum = edge_acc + {{WL{1'b0}}, edge_flag};
   assign pe_nxt   = {1'b0, high_sum} - HALF_V;
   assign win_end  = mon.enable && (win_cnt == {WL{1'b1}});

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         win_cnt        <= '0;
         high_acc       <= '0;
         edge_acc       <= '0;
         duty_q         <= '0;
         phase_error_q  <= '0;
         edge_count_q   <= '0;
         pump_stuck_q   <= 1'b0;
         result_valid_q <= 1'b0;
      end else if (!mon.enable) begin
         // Partial window is dropped; reported values stay as they were.
         win_cnt        <= '0;
         high_acc       <= '0;
         edge_acc       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         win_cnt        <= win_cnt + 1'b1;
         result_valid_q <= win_end;
         if (win_end) begin
            duty_q        <= high_sum;
            edge_count_q  <= edge_sum;
            phase_error_q <= $signed(pe_nxt);
            pump_stuck_q  <= (edge_sum < MIN_E);
            high_acc      <= '0;
            edge_acc      <= '0;
         end else begin
            high_acc      <= high_sum;
            edge_acc      <= edge_sum;
         end
      end
   end

   // ---------------- lock FSM ----------------
   lock_state_t      state_q, state_n;
   logic [CNT_W-1:0] good_cnt_q, good_cnt_n;
   logic [CNT_W-1:0] bad_cnt_q, bad_cnt_n;
   logic             good_win;

   // Judged from the registered results, i.e. during the result_valid cycle.
   assign good_win = (phase_error_q <= TOL_P) && (phase_error_q >= NTOL_P) &&
                     (edge_count_q >= MIN_E);

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= UNLOCKED;
         good_cnt_q <= '0;
         bad_cnt_q  <= '0;
      end else begin
         state_q    <= state_n;
         good_cnt_q <= good_cnt_n;
         bad_cnt_q  <= bad_cnt_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      good_cnt_n = good_cnt_q;
      bad_cnt_n  = bad_cnt_q;
      if (!mon.enable) begin
         state_n    = UNLOCKED;
         good_cnt_n = '0;
         bad_cnt_n  = '0;
      end else if (result_valid_q) begin
         case (state_q)
            UNLOCKED: begin
               if (good_win) begin
                  if ((good_cnt_q + 1'b1) == LOCK_C) begin
                     state_n    = LOCKED;
                     good_cnt_n = '0;
                     bad_cnt_n  = '0;
                  end else begin
                     good_cnt_n = good_cnt_q + 1'b1;
                  end
               end else begin
                  good_cnt_n = '0;
               end
            end
            LOCKED: begin
               if (!good_win) begin
                  if ((bad_cnt_q + 1'b1) == UNLOCK_C) begin
                     state_n    = UNLOCKED;
                     good_cnt_n = '0;
                     bad_cnt_n  = '0;
                  end else begin
                     bad_cnt_n = bad_cnt_q + 1'b1;
                  end
               end else begin
                  bad_cnt_n = '0;
               end
            end
            default: begin
               state_n    = UNLOCKED;
               good_cnt_n = '0;
               bad_cnt_n  = '0;
            end
         endcase
      end
   end

   // ---------------- outputs ----------------
   assign mon.duty         = duty_q;
   assign mon.phase_error  = phase_error_q;
   assign mon.edge_count   = edge_count_q;
   assign mon.pump_stuck   = pump_stuck_q;
   assign mon.result_valid = result_valid_q;
   assign mon.locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_pump_lock_monitor.sv
// Directed bench for pump_lock_monitor with WINDOW_LOG2=4, TOL=2, MIN_EDGES=2,
// LOCK_COUNT=2, UNLOCK_COUNT=2. Pump patterns are switched two cycles before a
// window closes so the synchronised sample changes exactly at the boundary.
module tb_pump_lock_monitor;

   localparam int WL = 4;

   logic clk_in = 1'b0;
   logic reset_n;

   always #5 clk_in = ~clk_in;

   pump_lock_monitor_if #(.WINDOW_LOG2(WL)) bus ();

   pump_lock_monitor #(
      .WINDOW_LOG2  (WL),
      .TOL          (2),
      .MIN_EDGES    (2),
      .LOCK_COUNT   (2),
      .UNLOCK_COUNT (2)
   ) dut (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .mon     (bus)
   );

   int errors = 0;
   int checks = 0;

   // pump pattern: high for pat_hi of every pat_per cycles
   int pat_hi  = 1;
   int pat_per = 1;
   int pat_ph  = 0;

   // captured per window
   int                first_rv;
   logic [WL:0]       c_duty;
   logic [WL:0]       c_edge;
   logic signed [WL+1:0] c_pe;
   logic              c_stuck;
   logic              lk_t1;
   logic              lk_rv;
   int                rv_seen;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: lands 1 time unit after the rising edge, then drives pump.
   task automatic tick();
      @(posedge clk_in);
      #1;
      bus.pump = (pat_ph < pat_hi);
      pat_ph   = (pat_ph + 1) % pat_per;
   endtask

   task automatic set_pattern(input int hi, input int per);
      pat_hi   = hi;
      pat_per  = per;
      bus.pump = (0 < hi);
      pat_ph   = 1 % per;
   endtask

   // Runs one 16-cycle window; per==0 keeps the running pattern, otherwise
   // the new pattern is applied so that the next window samples it exactly.
   task automatic window_check(input int nhi, input int nper);
      first_rv = 0;
      for (int t = 1; t <= 16; t++) begin
         tick();
         if (t == 1) lk_t1 = bus.locked;
         if (bus.result_valid && first_rv == 0) first_rv = t;
         if (t == 14 && nper != 0) set_pattern(nhi, nper);
      end
      c_duty  = bus.duty;
      c_edge  = bus.edge_count;
      c_pe    = bus.phase_error;
      c_stuck = bus.pump_stuck;
      lk_rv   = bus.locked;
   endtask

   initial begin
      reset_n    = 1'b0;
      bus.enable = 1'b0;
      set_pattern(1, 1);
      tick();
      tick();
      chk("rst_duty",  bus.duty, 0);
      chk("rst_pe",    bus.phase_error, 0);
      chk("rst_edges", bus.edge_count, 0);
      chk("rst_rv",    bus.result_valid, 0);
      chk("rst_lock",  bus.locked, 0);
      chk("rst_stuck", bus.pump_stuck, 0);

      // pump already high and settled through the synchroniser before enable
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      bus.enable = 1'b1;

      // W1: constant high; pulse in cycle 17 counting the enable cycle
      window_check(2, 4);
      chk("w1_rv_at",  first_rv, 16);
      chk("w1_duty",   c_duty, 16);
      chk("w1_pe",     c_pe, 8);
      chk("w1_edges",  c_edge, 0);
      chk("w1_stuck",  c_stuck, 1);
      chk("w1_lock",   lk_rv, 0);

      // W2: square, previous sample high -> 7 edges
      window_check(2, 4);
      chk("w2_rv_at",  first_rv, 16);
      chk("w2_duty",   c_duty, 8);
      chk("w2_pe",     c_pe, 0);
      chk("w2_edges",  c_edge, 7);
      chk("w2_stuck",  c_stuck, 0);
      chk("w2_lock",   lk_rv, 0);

      // W3: second good square window
      window_check(3, 4);
      chk("w3_duty",   c_duty, 8);
      chk("w3_edges",  c_edge, 8);
      chk("w3_lock_rv", lk_rv, 0);

      // W4: 3/4 duty, bad; locked rose the cycle after W3's pulse
      window_check(2, 4);
      chk("w4_lock_t1", lk_t1, 1);
      chk("w4_duty",   c_duty, 12);
      chk("w4_pe",     c_pe, 4);
      chk("w4_edges",  c_edge, 8);

      // W5: good again -> single bad window did not unlock
      window_check(3, 4);
      chk("w5_lock_t1", lk_t1, 1);
      chk("w5_duty",   c_duty, 8);
      chk("w5_pe",     c_pe, 0);

      // W6, W7: two consecutive bad windows
      window_check(3, 4);
      chk("w6_lock_t1", lk_t1, 1);
      chk("w6_duty",   c_duty, 12);
      window_check(10, 16);
      chk("w7_lock_t1", lk_t1, 1);
      chk("w7_pe",     c_pe, 4);
      chk("w7_lock_rv", lk_rv, 1);

      // W8: duty 10 (error == TOL), exactly MIN_EDGES edges -> good
      window_check(11, 16);
      chk("w8_lock_t1", lk_t1, 0);
      chk("w8_duty",   c_duty, 10);
      chk("w8_pe",     c_pe, 2);
      chk("w8_edges",  c_edge, 2);
      chk("w8_stuck",  c_stuck, 0);

      // W9: duty 11 (error TOL+1) -> bad, good run restarts
      window_check(10, 16);
      chk("w9_duty",   c_duty, 11);
      chk("w9_pe",     c_pe, 3);
      chk("w9_edges",  c_edge, 2);
      chk("w9_lock_rv", lk_rv, 0);

      // W10, W11: two TOL-edge good windows -> lock
      window_check(10, 16);
      chk("w10_lock_t1", lk_t1, 0);
      chk("w10_duty",  c_duty, 10);
      window_check(2, 4);
      chk("w11_lock_t1", lk_t1, 0);
      chk("w11_duty",  c_duty, 10);
      tick();
      chk("w11_locked_after", bus.locked, 1);

      // Disable mid-window while locked
      for (int i = 0; i < 5; i++) tick();
      bus.enable = 1'b0;
      tick();
      chk("dis_lock",  bus.locked, 0);
      chk("dis_rv",    bus.result_valid, 0);
      chk("dis_duty",  bus.duty, 10);
      chk("dis_pe",    bus.phase_error, 2);
      chk("dis_edges", bus.edge_count, 2);
      chk("dis_stuck", bus.pump_stuck, 0);
      rv_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.result_valid) rv_seen++;
      end
      chk("dis_no_rv",     rv_seen, 0);
      chk("dis_duty_hold", bus.duty, 10);

      // Re-enable: fresh full window, pulse in cycle 17 counting enable cycle
      bus.enable = 1'b1;
      window_check(0, 0);
      chk("ren_rv_at", first_rv, 16);
      chk("ren_duty",  c_duty, 8);
      chk("ren_pe",    c_pe, 0);
      chk("ren_edges", c_edge, 8);
      chk("ren_lock",  lk_rv, 0);

      // Asynchronous reset between clock edges, mid-window
      for (int i = 0; i < 5; i++) tick();
      @(posedge clk_in);
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_duty",  bus.duty, 0);
      chk("arst_pe",    bus.phase_error, 0);
      chk("arst_edges", bus.edge_count, 0);
      chk("arst_rv",    bus.result_valid, 0);
      chk("arst_lock",  bus.locked, 0);
      chk("arst_stuck", bus.pump_stuck, 0);
      tick();
      tick();

      // Release with enable high; synchroniser restarts from 0, so the first
      // two samples are low and the window sees 7 edges.
      set_pattern(2, 4);
      reset_n = 1'b1;
      window_check(0, 0);
      chk("post_rv_at", first_rv, 16);
      chk("post_duty",  c_duty, 8);
      chk("post_pe",    c_pe, 0);
      chk("post_edges", c_edge, 7);
      chk("post_stuck", c_stuck, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
